// File: rtl/shift_register_ctrl.sv
// Sequencer for a bidirectional serial shift register: loads a parallel word with right
// shifts, then unloads it with left shifts while capturing QL. Option: SHREG_CTRL_LOOPBACK_CHECK_EN.
module shift_register_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic             sel,
   output logic             ser_out,
   input  logic             ql_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] data_out,
   output logic             err
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_UNLOAD,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_word;
   logic [WIDTH-1:0] r_capture;
   logic [CW-1:0]    w_cntInc;
   logic [WIDTH-1:0] w_capNext;

   assign w_cntInc  = r_cnt + 1'b1;
   // Capture value including the bit arriving on this edge, so data_out sees the full word in DONE.
   assign w_capNext = {r_capture[WIDTH-2:0], ql_in};

`ifdef SHREG_CTRL_LOOPBACK_CHECK_EN
   logic r_err;
   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_word    <= '0;
         r_capture <= '0;
         sel       <= 1'b0;
         ser_out   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         data_out  <= '0;
`ifdef SHREG_CTRL_LOOPBACK_CHECK_EN
         r_err     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt   <= '0;
               sel     <= 1'b0;
               ser_out <= 1'b0;
               done    <= 1'b0;
               busy    <= 1'b0;
               if (start) begin
                  r_state <= S_LOAD;
                  r_word  <= data_in;
                  sel     <= 1'b1;
                  ser_out <= data_in[0];
                  busy    <= 1'b1;
`ifdef SHREG_CTRL_LOOPBACK_CHECK_EN
                  r_err   <= 1'b0;
`endif
               end
            end
            S_LOAD: begin
               if (r_cnt == LAST) begin
                  r_state <= S_UNLOAD;
                  r_cnt   <= '0;
                  sel     <= 1'b0;
                  ser_out <= 1'b0;
               end else begin
                  r_cnt   <= w_cntInc;
                  ser_out <= r_word[w_cntInc];
               end
            end
            S_UNLOAD: begin
               r_capture <= w_capNext;
               if (r_cnt == LAST) begin
                  r_state  <= S_DONE;
                  r_cnt    <= '0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  data_out <= w_capNext;
`ifdef SHREG_CTRL_LOOPBACK_CHECK_EN
                  r_err    <= (w_capNext != r_word);
`endif
               end else begin
                  r_cnt <= w_cntInc;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               done    <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Self-checking bench for shift_register_ctrl: WIDTH=4 and WIDTH=8 instances, each driving
// a behavioural shift-register model; results go through a scoreboard queue.
module tb_shift_register_ctrl;

`ifdef SHREG_CTRL_LOOPBACK_CHECK_EN
   localparam bit LOOPBACK = 1'b1;
`else
   localparam bit LOOPBACK = 1'b0;
`endif

   logic       Clk;
   logic       Rst;
   bit         clkEn;

   logic       start4, start8;
   logic [3:0] dataIn4;
   logic [7:0] dataIn8;
   logic       sel4, ser4, ql4, busy4, done4, err4;
   logic       sel8, ser8, ql8, busy8, done8, err8;
   logic [3:0] dataOut4;
   logic [7:0] dataOut8;

   logic [3:0] reg4;
   logic [7:0] reg8;
   bit         qlForce;

   int         checks;
   int         failures;
   logic [7:0] expQ[$];

   shift_register_ctrl #(.WIDTH(4)) dut4 (
      .Clk(Clk), .Rst(Rst), .start(start4), .data_in(dataIn4),
      .sel(sel4), .ser_out(ser4), .ql_in(ql4), .busy(busy4),
      .done(done4), .data_out(dataOut4), .err(err4)
   );

   shift_register_ctrl #(.WIDTH(8)) dut8 (
      .Clk(Clk), .Rst(Rst), .start(start8), .data_in(dataIn8),
      .sel(sel8), .ser_out(ser8), .ql_in(ql8), .busy(busy8),
      .done(done8), .data_out(dataOut8), .err(err8)
   );

   // Gated clock so reset can be checked with the clock stopped.
   initial Clk = 1'b0;
   always begin
      #5;
      if (clkEn) Clk = ~Clk;
   end

   // Behavioural model of the external bidirectional shift registers.
   always @(posedge Clk) begin
      if (sel4) reg4 <= {ser4, reg4[3:1]};
      else      reg4 <= {reg4[2:0], ser4};
      if (sel8) reg8 <= {ser8, reg8[7:1]};
      else      reg8 <= {reg8[6:0], ser8};
   end

   assign ql4 = qlForce ? 1'b0 : reg4[3];
   assign ql8 = reg8[7];

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input bit use8, input logic [7:0] word);
      if (use8) begin
         start8  = 1'b1;
         dataIn8 = word;
      end else begin
         start4  = 1'b1;
         dataIn4 = word[3:0];
      end
   endtask

   // Counts edges until done is seen, bounded so a stuck DUT cannot hang the run.
   task automatic waitDone(input bit use8, output int n);
      n = 0;
      while (((use8 ? done8 : done4) !== 1'b1) && n < 60) begin
         tick();
         n++;
      end
      checkOutput(use8 ? "doneTimeout8" : "doneTimeout4", {31'd0, (use8 ? done8 : done4)}, 32'd1);
   endtask

   function automatic logic [7:0] popExp();
      logic [7:0] v;
      if (expQ.size() == 0) return 8'hxx;
      v = expQ.pop_front();
      return v;
   endfunction

   initial begin
      logic [3:0] word;
      int         n;
      bit         sawDone;

      checks   = 0;
      failures = 0;
      qlForce  = 1'b0;
      clkEn    = 1'b0;
      Rst      = 1'b0;
      start4   = 1'b0;
      start8   = 1'b0;
      dataIn4  = 4'h0;
      dataIn8  = 8'h00;

      // Reset with the clock stopped
      #3 Rst = 1'b1;
      #1;
      checkOutput("rstSel",     {31'd0, sel4},     32'd0);
      checkOutput("rstSerOut",  {31'd0, ser4},     32'd0);
      checkOutput("rstBusy",    {31'd0, busy4},    32'd0);
      checkOutput("rstDone",    {31'd0, done4},    32'd0);
      checkOutput("rstDataOut", {28'd0, dataOut4}, 32'd0);
      checkOutput("rstErr",     {31'd0, err4},     32'd0);
      checkOutput("rstBusy8",   {31'd0, busy8},    32'd0);
      checkOutput("rstDataOut8",{24'd0, dataOut8}, 32'd0);
      #2 Rst = 1'b0;
      clkEn = 1'b1;
      repeat (3) tick();

      // Round trip 4'b1101 with bit-level checks of ser_out and ql_in
      word = 4'b1101;
      applyStimulus(1'b0, {4'd0, word});
      expQ.push_back({4'd0, word});
      tick();
      start4  = 1'b0;
      dataIn4 = 4'h0;
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("loadSel%0d", k), {31'd0, sel4},  32'd1);
         checkOutput($sformatf("loadBusy%0d", k), {31'd0, busy4}, 32'd1);
         checkOutput($sformatf("loadBit%0d", k), {31'd0, ser4},  {31'd0, word[k]});
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("unloadSel%0d", k), {31'd0, sel4}, 32'd0);
         checkOutput($sformatf("unloadQl%0d", k),  {31'd0, ql4},  {31'd0, word[3-k]});
         checkOutput($sformatf("unloadDone%0d", k), {31'd0, done4}, 32'd0);
         tick();
      end
      checkOutput("rtDone",    {31'd0, done4},    32'd1);
      checkOutput("rtBusy",    {31'd0, busy4},    32'd0);
      checkOutput("rtDataOut", {28'd0, dataOut4}, {24'd0, popExp()});
      checkOutput("rtErr",     {31'd0, err4},     32'd0);
      tick();
      checkOutput("rtDonePulse", {31'd0, done4}, 32'd0);
      checkOutput("rtHold",      {28'd0, dataOut4}, 32'hD);

      // start held high: 4'hA then 4'h5, one acceptance per 10 edges
      applyStimulus(1'b0, 8'h0A);
      expQ.push_back(8'h0A);
      tick();
      dataIn4 = 4'h5;
      waitDone(1'b0, n);
      checkOutput("heldLatency", n, 32'd8);
      checkOutput("heldWordA", {28'd0, dataOut4}, {24'd0, popExp()});
      expQ.push_back(8'h05);
      tick();
      checkOutput("heldGapBusy", {31'd0, busy4}, 32'd0);
      waitDone(1'b0, n);
      checkOutput("heldPeriod", n + 1, 32'd10);
      checkOutput("heldWord5", {28'd0, dataOut4}, {24'd0, popExp()});
      start4 = 1'b0;
      repeat (3) tick();

      // Reset pulse in UNLOAD cycle 2
      applyStimulus(1'b0, 8'h09);
      tick();
      start4 = 1'b0;
      repeat (6) tick();
      Rst = 1'b1;
      #1;
      checkOutput("midRstBusy",    {31'd0, busy4},    32'd0);
      checkOutput("midRstDataOut", {28'd0, dataOut4}, 32'd0);
      #1 Rst = 1'b0;
      sawDone = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done4 !== 1'b0) sawDone = 1'b1;
      end
      checkOutput("midRstNoDone",  {31'd0, sawDone},  32'd0);
      checkOutput("midRstKeep0",   {28'd0, dataOut4}, 32'd0);
      applyStimulus(1'b0, 8'h06);
      expQ.push_back(8'h06);
      tick();
      start4 = 1'b0;
      waitDone(1'b0, n);
      checkOutput("postRstLatency", n, 32'd8);
      checkOutput("postRstWord", {28'd0, dataOut4}, {24'd0, popExp()});
      repeat (2) tick();

      // Broken loopback: ql_in forced low
      qlForce = 1'b1;
      applyStimulus(1'b0, 8'h0B);
      expQ.push_back(8'h00);
      tick();
      start4 = 1'b0;
      waitDone(1'b0, n);
      checkOutput("lbWord", {28'd0, dataOut4}, {24'd0, popExp()});
      checkOutput("lbErr",  {31'd0, err4}, {31'd0, LOOPBACK});
      tick();
      checkOutput("lbErrHold", {31'd0, err4}, {31'd0, LOOPBACK});
      qlForce = 1'b0;
      tick();
      applyStimulus(1'b0, 8'h03);
      expQ.push_back(8'h03);
      tick();
      start4 = 1'b0;
      checkOutput("lbErrClear", {31'd0, err4}, 32'd0);
      waitDone(1'b0, n);
      checkOutput("lbGoodWord", {28'd0, dataOut4}, {24'd0, popExp()});
      checkOutput("lbGoodErr",  {31'd0, err4}, 32'd0);
      repeat (2) tick();

      // WIDTH=8 round trip
      applyStimulus(1'b1, 8'hC3);
      expQ.push_back(8'hC3);
      tick();
      start8  = 1'b0;
      dataIn8 = 8'h00;
      waitDone(1'b1, n);
      checkOutput("w8Latency", n, 32'd16);
      checkOutput("w8Word", {24'd0, dataOut8}, {24'd0, popExp()});
      checkOutput("w8Err",  {31'd0, err8}, 32'd0);
      tick();
      checkOutput("w8DonePulse", {31'd0, done8}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shift_register_ctrl.md
# shift_register_ctrl

Sequencer for the team's bidirectional serial shift register (serial input `in`, direction select `sel`, taps `QL`/`QR`, free-running on `Clk`, no enable). On a `start` request it latches a parallel word, shifts it serially into the register with right shifts, then shifts it back out with left shifts while capturing `QL` into a parallel result. It sits between a parallel requester and the shift-register datapath and owns the `sel`/`in` drive for the whole transfer.

## Interface
- `WIDTH`, default 4: depth of the controlled register in bits (≥2); also the width of the data words.
- `Clk`  input  1  rising-edge clock, shared with the shift register.
- `Rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  transfer request, sampled on `Clk` rise.
- `data_in`  input  WIDTH  word to load, latched when `start` is accepted.
- `sel`  output  1  to register `sel`: 1 = shift right (load), 0 = shift left (unload).
- `ser_out`  output  1  to register `in`.
- `ql_in`  input  1  from register `QL` (MSB tap).
- `busy`  output  1  high in LOAD and UNLOAD.
- `done`  output  1  one-cycle completion pulse.
- `data_out`  output  WIDTH  captured word, valid from the `done` pulse until the next accepted `start`.
- `err`  output  1  loopback mismatch flag (see Configuration).

## Operation
- Register model, bits r[WIDTH-1:0]: `sel`=1 gives r <= {in, r[WIDTH-1:1]}; `sel`=0 gives r <= {r[WIDTH-2:0], in}; `QL` = r[WIDTH-1].
- States:
  - IDLE: `sel`=0, `ser_out`=0. The register keeps shifting left and fills with zeros. Its contents are don't-care.
  - LOAD: `sel`=1 for exactly WIDTH cycles. `ser_out` = latched bit k in LOAD cycle k (k = 0..WIDTH-1), so bit 0 goes first. After the last edge, r equals the latched word.
  - UNLOAD: `sel`=0 and `ser_out`=0 for exactly WIDTH cycles. Each edge does capture <= {capture[WIDTH-2:0], ql_in}. After WIDTH edges, capture equals the original word (MSB first out).
  - DONE: exactly one cycle. `done`=1, `busy`=0, and `data_out` is updated from capture. Then the state returns to IDLE.
- Counter: $clog2(WIDTH) bits. It clears on every state entry and the terminal count is WIDTH-1.
- `start` is accepted only in IDLE. It is ignored in LOAD, UNLOAD and DONE; requests are not queued.
- `data_in` changes after acceptance have no effect.

## Timing
- Reset values (asynchronous): state IDLE, `sel`=0, `ser_out`=0, `busy`=0, `done`=0, `data_out`=0, `err`=0, counter=0.
- Rst asserted mid-transfer: immediate return to IDLE with reset values. The partially shifted word is discarded and no `done` is issued.
- `start`=1 sampled at edge E0 in IDLE moves the state to LOAD after E0. From then on `sel` and `busy` are high.
- LOAD occupies the cycles after edges E0..E(W-1), where W = WIDTH.
- UNLOAD occupies the cycles after E(W)..E(2W-1).
- `done` is high in the cycle after E(2W). Latency from the accepting edge to `done` is 2W+1 cycles.
- The next `start` can be accepted at the edge ending DONE+1, i.e. E(2W+2) at the earliest. Throughput is one transfer per 2W+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SHREG_CTRL_LOOPBACK_CHECK_EN` defined:
  - The block compares the captured word against the latched `data_in` at the UNLOAD→DONE transition.
  - `err` is set to (capture != latched) in the DONE cycle and holds until the next accepted `start` or `Rst`.
- Not defined: no comparator is built, and `err` is tied to 0.

## Test plan
- Reset: assert `Rst` mid-cycle with `Clk` stopped. All outputs read 0 immediately and the state is IDLE.
- Round trip, WIDTH=4, `data_in`=4'b1101, with the register model attached:
  - `ser_out` sequence in LOAD is 1,0,1,1.
  - `ql_in` sequence in UNLOAD is 1,1,0,1.
  - `done` pulses 9 cycles after acceptance, `data_out`=4'b1101 and `err`=0.
- `start` held high continuously with `data_in`=4'hA then 4'h5:
  - Transfers are accepted only every 10 cycles, and `data_in` changes mid-transfer are ignored.
  - Successive `data_out` values are 4'hA, then 4'h5.
- `Rst` pulse during UNLOAD cycle 2:
  - `busy` drops and `done` never pulses.
  - `data_out` stays 0, and a following transfer of 4'h6 completes correctly.
- With `SHREG_CTRL_LOOPBACK_CHECK_EN`, loading 4'b1011 and forcing `ql_in`=0 throughout: `done` pulses with `data_out`=0 and `err`=1. A following good transfer clears `err`.
- WIDTH=8, `data_in`=8'hC3: `done` arrives at 17 cycles and `data_out`=8'hC3.
